sm4_request_arbiter: RTL
========================

Name: sm4_request_arbiter

Overview:
- Shares one sm4_encryptor core between num_req_p independent requesters.
- Round-robin arbitration; exactly one operation in flight; the result is routed back to the owning requester.
- Also sequences core cache invalidation (flush) so it never overlaps an active operation.
- Sits between the requester fabric and the core's content/key/v/ready and crypt/v/yumi/invalid_cache ports.

Parameters:
- num_req_p, 4, number of requesters (2..8); owner ID width is $clog2(num_req_p).
- group_size_p, 128, SM4 block/key width; equals sm4_encryptor_pkg::group_size_p.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset
- req_v_i  in  num_req_p  per-requester request valid
- req_ready_o  out  num_req_p  per-requester accept; at most one bit set
- req_content_i  in  num_req_p x group_size_p  per-requester data block
- req_key_i  in  num_req_p x group_size_p  per-requester key
- req_decode_i  in  num_req_p  1 = decrypt
- resp_v_o  out  num_req_p  one-hot result valid to owner
- resp_data_o  out  group_size_p  result, shared bus
- resp_yumi_i  in  num_req_p  owner consumes result
- flush_i  in  1  request core cache invalidation (pulse or level)
- flush_done_o  out  1  one-cycle pulse when invalidation has been issued
- core_content_o / core_key_o  out  group_size_p  to core content_i / key_i
- core_decode_o  out  1  to core encode_or_decode_i
- core_v_o  out  1  to core v_i
- core_ready_i  in  1  from core ready_o
- core_crypt_i  in  group_size_p  from core crypt_o
- core_v_i  in  1  from core v_o
- core_yumi_o  out  1  to core yumi_i
- core_invalid_cache_o  out  1  to core invalid_cache_i
- busy_o  out  1  state != IDLE
- owner_o  out  $clog2(num_req_p)  ID of the current or last granted requester

Interface rules:
- Single clock clk_i.
- reset_n_i is asynchronous and active-low.

Behaviour:
- Reset (async assert) values:
  - FSM = IDLE; rr pointer = 0; flush_pend = 0.
  - All outputs 0, including data/key registers and owner_o.
- FSM states: IDLE, ISSUE, WAIT, RESP, FLUSH.
- IDLE:
  - If flush_pend | flush_i: go to FLUSH; no req_ready_o is asserted that cycle.
  - Else choose the winner: first set req_v_i bit scanning upward from rr pointer, wrapping modulo num_req_p.
  - req_ready_o[winner] = 1 combinationally, for that cycle only.
  - On handshake: latch content/key/decode into registers, set owner_o = winner, set rr pointer = (winner+1) mod num_req_p, go to ISSUE.
  - No request pending: stay in IDLE; pointer unchanged.
- ISSUE:
  - core_v_o = 1 with registered operands, held stable until core_ready_i.
  - Handshake cycle (core_v_o & core_ready_i): go to WAIT.
- WAIT:
  - On core_v_i: capture core_crypt_i into the result register and assert core_yumi_o in the same cycle (combinational on core_v_i); go to RESP.
  - core_yumi_o is never asserted outside WAIT.
- RESP:
  - resp_v_o[owner] = 1; resp_data_o = result register, stable until consumed.
  - resp_yumi_i[owner] returns to IDLE; resp_yumi_i bits of non-owners are ignored.
- FLUSH:
  - core_invalid_cache_o = 1 for exactly one cycle; clear flush_pend.
  - Next cycle: flush_done_o = 1 and return to IDLE.
- Flush while busy: flush_i outside IDLE sets flush_pend; it is serviced at the next IDLE, before any new grant. Multiple flush pulses while pending merge into one.
- Latency:
  - Request handshake at cycle t; core_v_o at t+1.
  - resp_v_o at the cycle after core_v_i.
  - Requester-side overhead is 2 cycles plus core latency.
- Fairness: with all requesters asserted continuously, grants rotate 0,1,2,3,0,...
- Requests deasserted before the handshake are dropped silently; no state change.
- resp_data_o holds its last value outside RESP; only resp_v_o qualifies it.
- Async reset mid-operation aborts everything and returns to the reset values. The core shares reset_n_i (inverted) so no stale core_v_i survives.

Optional Feature:
- SM4_ARB_PRIORITY_EN:
  - Defined: requester 0 has strict priority. It wins whenever req_v_i[0] is set, regardless of the rr pointer, and a requester-0 grant does not move the pointer. Requesters 1..N-1 round-robin among themselves.
  - Undefined: pure round-robin across all requesters as described above.

Test Plan:
- Single encrypt: req0 with key = content = 0123456789abcdeffedcba9876543210, decode=0 -> resp_v_o=4'b0001, resp_data_o=681edf34d206965e86b3e94f536e4246; core_v_o asserted exactly 1 cycle after req_ready_o[0].
- Decrypt round trip: req2 with content 681edf34d206965e86b3e94f536e4246 and the same key, decode=1 -> resp_v_o=4'b0100, resp_data_o=0123456789abcdeffedcba9876543210.
- Fairness: all four req_v_i held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; with SM4_ARB_PRIORITY_EN -> 0,0,... while req0 is held.
- Backpressure: hold resp_yumi_i low for 10 cycles in RESP; pulse resp_yumi_i[1] for non-owner 3 -> resp_v_o and resp_data_o stable, FSM stays in RESP; owner yumi returns to IDLE.
- Flush collision: pulse flush_i during WAIT with req1 pending -> RESP completes first; next IDLE goes to FLUSH with a 1-cycle core_invalid_cache_o, then flush_done_o; req1 is granted after.
- Reset mid-op: deassert reset_n_i during WAIT -> all outputs 0 immediately (asynchronous); after release, the next request is served normally from rr pointer 0.

Source files
------------

// File: rtl/sm4_request_arbiter.sv
// Shares one sm4_encryptor core among num_req_p requesters: round-robin grant, one op in flight,
// flush sequenced between operations. Define SM4_ARB_PRIORITY_EN to give requester 0 strict priority.
module sm4_request_arbiter #(
  parameter int num_req_p    = 4,
  parameter int group_size_p = 128
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  input  logic [num_req_p-1:0][group_size_p-1:0] req_content_i,
  input  logic [num_req_p-1:0][group_size_p-1:0] req_key_i,
  input  logic [num_req_p-1:0]                   req_decode_i,
  output logic [num_req_p-1:0]                   resp_v_o,
  output logic [group_size_p-1:0]                resp_data_o,
  input  logic [num_req_p-1:0]                   resp_yumi_i,
  input  logic                                   flush_i,
  output logic                                   flush_done_o,
  output logic [group_size_p-1:0]                core_content_o,
  output logic [group_size_p-1:0]                core_key_o,
  output logic                                   core_decode_o,
  output logic                                   core_v_o,
  input  logic                                   core_ready_i,
  input  logic [group_size_p-1:0]                core_crypt_i,
  input  logic                                   core_v_i,
  output logic                                   core_yumi_o,
  output logic                                   core_invalid_cache_o,
  output logic                                   busy_o,
  output logic [$clog2(num_req_p)-1:0]           owner_o
);

  localparam int                 id_w_lp    = $clog2(num_req_p);
  localparam logic [id_w_lp-1:0] last_id_lp = id_w_lp'(num_req_p - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [id_w_lp-1:0]      rr_q, rr_d;
  logic [id_w_lp-1:0]      owner_q, owner_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    flush_done_q, flush_done_d;
  logic [group_size_p-1:0] content_q, content_d;
  logic [group_size_p-1:0] key_q, key_d;
  logic                    decode_q, decode_d;
  logic [group_size_p-1:0] result_q, result_d;

  logic [num_req_p-1:0]    cand;
  logic [id_w_lp-1:0]      winner;
  logic [id_w_lp-1:0]      winner_inc;
  logic                    winner_v;
  logic                    grant_pri;

  // Winner: first candidate at or above the rr pointer, wrapping.
  always_comb begin
    cand      = req_v_i;
    winner    = '0;
    winner_v  = 1'b0;
    grant_pri = 1'b0;
`ifdef SM4_ARB_PRIORITY_EN
    cand[0]   = 1'b0;
`endif
    for (int i = 0; i < num_req_p; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % num_req_p;
      if (!winner_v && cand[idx]) begin
        winner_v = 1'b1;
        winner   = idx[id_w_lp-1:0];
      end
    end
`ifdef SM4_ARB_PRIORITY_EN
    if (req_v_i[0]) begin
      winner_v  = 1'b1;
      winner    = '0;
      grant_pri = 1'b1;
    end
`endif
    winner_inc = (winner == last_id_lp) ? '0 : winner + 1'b1;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d              = state_q;
    rr_d                 = rr_q;
    owner_d              = owner_q;
    content_d            = content_q;
    key_d                = key_q;
    decode_d             = decode_q;
    result_d             = result_q;
    flush_done_d         = 1'b0;
    flush_pend_d         = flush_pend_q | (flush_i && state_q != ST_IDLE);
    req_ready_o          = '0;
    resp_v_o             = '0;
    core_v_o             = 1'b0;
    core_yumi_o          = 1'b0;
    core_invalid_cache_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_pend_q || flush_i) begin
          state_d = ST_FLUSH;
        end else if (winner_v) begin
          // Ready is the only input-driven output in IDLE; keep it quiet while reset is held.
          req_ready_o[winner] = reset_n_i;
          owner_d             = winner;
          content_d           = req_content_i[winner];
          key_d               = req_key_i[winner];
          decode_d            = req_decode_i[winner];
          rr_d                = grant_pri ? rr_q : winner_inc;
          state_d             = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_v_o = 1'b1;
        if (core_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        core_yumi_o = core_v_i;
        if (core_v_i) begin
          result_d = core_crypt_i;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_v_o[owner_q] = 1'b1;
        if (resp_yumi_i[owner_q]) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        core_invalid_cache_o = 1'b1;
        flush_pend_d         = 1'b0;
        flush_done_d         = 1'b1;
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: operand/result registers are reset too, so a mid-op reset leaves no stale data on the buses.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      owner_q      <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      content_q    <= '0;
      key_q        <= '0;
      decode_q     <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      content_q    <= content_d;
      key_q        <= key_d;
      decode_q     <= decode_d;
      result_q     <= result_d;
    end
  end

  assign core_content_o = content_q;
  assign core_key_o     = key_q;
  assign core_decode_o  = decode_q;
  assign resp_data_o    = result_q;
  assign flush_done_o   = flush_done_q;
  assign owner_o        = owner_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
